// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - two-master round-robin arbiter and datapath mux for the shared gpiomem bus
module shared_bus_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core0_request,
  output logic              core0_grant,
  input  logic [DATA_W-1:0] core0_data_in,
  output logic [DATA_W-1:0] core0_data_out,
  input  logic [ADDR_W-1:0] core0_address,
  input  logic              core0_rw,
  input  logic              core1_request,
  output logic              core1_grant,
  input  logic [DATA_W-1:0] core1_data_in,
  output logic [DATA_W-1:0] core1_data_out,
  input  logic [ADDR_W-1:0] core1_address,
  input  logic              core1_rw,
  output logic [ADDR_W-1:0] RAM_address,
  output logic [DATA_W-1:0] RAM_data_in,
  input  logic [DATA_W-1:0] RAM_data_out,
  output logic              rw
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C0   = 2'd1,
    C1   = 2'd2
  } owner_t;

  owner_t owner;
  logic   last_served;

  // A released owner is re-arbitrated in the same edge, so the other core
  // can take over without an idle cycle in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= IDLE;
      last_served <= 1'b1;
    end else if (owner == C0 && core0_request) begin
      owner <= C0;
    end else if (owner == C1 && core1_request) begin
      owner <= C1;
    end else if (core0_request && core1_request) begin
      if (last_served) begin
        owner       <= C0;
        last_served <= 1'b0;
      end else begin
        owner       <= C1;
        last_served <= 1'b1;
      end
    end else if (core0_request) begin
      owner       <= C0;
      last_served <= 1'b0;
    end else if (core1_request) begin
      owner       <= C1;
      last_served <= 1'b1;
    end else begin
      owner <= IDLE;
    end
  end

  assign core0_grant = (owner == C0);
  assign core1_grant = (owner == C1);

  always_comb begin
    RAM_address    = '0;
    RAM_data_in    = '0;
    rw             = 1'b0;
    core0_data_out = '0;
    core1_data_out = '0;
    case (owner)
      C0: begin
        RAM_address    = core0_address;
        RAM_data_in    = core0_data_in;
        rw             = core0_rw;
        core0_data_out = RAM_data_out;
      end
      C1: begin
        RAM_address    = core1_address;
        RAM_data_in    = core1_data_in;
        rw             = core1_rw;
        core1_data_out = RAM_data_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// tb/tb_shared_bus_arbiter.sv - directed self-checking bench for shared_bus_arbiter
module tb_shared_bus_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              core0_request, core1_request;
  logic              core0_grant, core1_grant;
  logic [DATA_W-1:0] core0_data_in, core1_data_in;
  logic [DATA_W-1:0] core0_data_out, core1_data_out;
  logic [ADDR_W-1:0] core0_address, core1_address;
  logic              core0_rw, core1_rw;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_data_in;
  logic [DATA_W-1:0] RAM_data_out;
  logic              rw;

  int errors = 0;
  int checks = 0;

  shared_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .core0_request  (core0_request),
    .core0_grant    (core0_grant),
    .core0_data_in  (core0_data_in),
    .core0_data_out (core0_data_out),
    .core0_address  (core0_address),
    .core0_rw       (core0_rw),
    .core1_request  (core1_request),
    .core1_grant    (core1_grant),
    .core1_data_in  (core1_data_in),
    .core1_data_out (core1_data_out),
    .core1_address  (core1_address),
    .core1_rw       (core1_rw),
    .RAM_address    (RAM_address),
    .RAM_data_in    (RAM_data_in),
    .RAM_data_out   (RAM_data_out),
    .rw             (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset          = 1'b1;
    core0_request  = 1'b1;
    core1_request  = 1'b1;
    core0_data_in  = '0;
    core1_data_in  = '0;
    core0_address  = '0;
    core1_address  = '0;
    core0_rw       = 1'b0;
    core1_rw       = 1'b0;
    RAM_data_out   = '0;

    // reset held two cycles with both requests high
    tick();
    tick();
    check("rst_g0",   32'(core0_grant), 32'd0);
    check("rst_g1",   32'(core1_grant), 32'd0);
    check("rst_rw",   32'(rw), 32'd0);
    check("rst_addr", 32'(RAM_address), 32'h000);
    check("rst_d0",   32'(core0_data_out), 32'h00);

    // single master write
    core1_request = 1'b0;
    core0_address = 9'h105;
    core0_rw      = 1'b1;
    core0_data_in = 8'hA5;
    core1_address = 9'h0AA;
    core1_rw      = 1'b1;
    core1_data_in = 8'h5A;
    RAM_data_out  = 8'h77;
    reset         = 1'b0;
    tick();
    check("single_g0",    32'(core0_grant), 32'd1);
    check("single_g1",    32'(core1_grant), 32'd0);
    check("single_addr",  32'(RAM_address), 32'h105);
    check("single_wdata", 32'(RAM_data_in), 32'hA5);
    check("single_rw",    32'(rw), 32'd1);
    check("single_d1",    32'(core1_data_out), 32'h00);
    check("single_d0",    32'(core0_data_out), 32'h77);

    // tie right after reset goes to core0, handoff without idle cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core0_request = 1'b1;
    core1_request = 1'b1;
    tick();
    check("tie_g0", 32'(core0_grant), 32'd1);
    check("tie_g1", 32'(core1_grant), 32'd0);
    core0_request = 1'b0;
    tick();
    check("handoff_g1",   32'(core1_grant), 32'd1);
    check("handoff_g0",   32'(core0_grant), 32'd0);
    check("handoff_addr", 32'(RAM_address), 32'h0AA);

    // idle bus drives zeros
    core1_request = 1'b0;
    tick();
    check("idle_g0",    32'(core0_grant), 32'd0);
    check("idle_g1",    32'(core1_grant), 32'd0);
    check("idle_rw",    32'(rw), 32'd0);
    check("idle_addr",  32'(RAM_address), 32'h000);
    check("idle_wdata", 32'(RAM_data_in), 32'h00);

    // round-robin: core1 served last, so core0 wins the tie
    core0_request = 1'b1;
    core1_request = 1'b1;
    tick();
    check("rr1_g0", 32'(core0_grant), 32'd1);
    core0_request = 1'b0;
    tick();
    check("rr2_g1", 32'(core1_grant), 32'd1);
    core0_request = 1'b1;
    core1_request = 1'b0;
    tick();
    check("rr3_g0", 32'(core0_grant), 32'd1);
    core1_request = 1'b1;
    tick();
    check("nopreempt_g0", 32'(core0_grant), 32'd1);
    check("nopreempt_g1", 32'(core1_grant), 32'd0);
    core0_request = 1'b0;
    core1_request = 1'b0;
    tick();
    core0_request = 1'b1;
    core1_request = 1'b1;
    tick();
    check("rr_tie_g1", 32'(core1_grant), 32'd1);
    check("rr_tie_g0", 32'(core0_grant), 32'd0);

    // isolation: core1 reads while core0 drives write strobe
    core1_rw      = 1'b0;
    core1_address = 9'h1F0;
    core1_data_in = 8'h66;
    RAM_data_out  = 8'h3C;
    core0_rw      = 1'b1;
    core0_address = 9'h0FF;
    core0_data_in = 8'h99;
    #1;
    check("iso_d1",   32'(core1_data_out), 32'h3C);
    check("iso_d0",   32'(core0_data_out), 32'h00);
    check("iso_rw",   32'(rw), 32'd0);
    check("iso_addr", 32'(RAM_address), 32'h1F0);
    core0_address = 9'h011;
    tick();
    check("iso2_g1",    32'(core1_grant), 32'd1);
    check("iso2_addr",  32'(RAM_address), 32'h1F0);
    check("iso2_wdata", 32'(RAM_data_in), 32'h66);
    check("iso2_rw",    32'(rw), 32'd0);

    // reset in the middle of a core0 write
    core1_request = 1'b0;
    tick();
    check("midop_g0", 32'(core0_grant), 32'd1);
    check("midop_rw", 32'(rw), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_g0", 32'(core0_grant), 32'd0);
    check("midrst_rw", 32'(rw), 32'd0);
    reset         = 1'b0;
    core1_request = 1'b1;
    tick();
    check("postrst_g0", 32'(core0_grant), 32'd1);
    check("postrst_g1", 32'(core1_grant), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
